// File: rtl/bless_rank_stage.sv
// Purpose: latch N/E/S/W arrivals plus one local injection, eject one local flit, rank the rest oldest-first with ppv.
// Latency: one cycle from in_*/inj_* to rank_*/eject_*.
// Backpressure: none on network inputs; injection is refused only while all four slots stay occupied.
module bless_rank_stage #(
    parameter int DATA_W = 32,
    parameter int XY_W   = 3,
    parameter int AGE_W  = 8,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0,
    parameter int FLIT_W = DATA_W + 2*XY_W + AGE_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          in_valid,
    input  logic [4*FLIT_W-1:0] in_flit,
    input  logic                inj_valid,
    input  logic [FLIT_W-1:0]   inj_flit,
    output logic                inj_ready,
    output logic [3:0]          rank_valid,
    output logic [4*FLIT_W-1:0] rank_flit,
    output logic [15:0]         rank_ppv,
    output logic [3:0]          rank_mc,
    output logic [2:0]          rank_cnt,
    output logic                eject_valid,
    output logic [FLIT_W-1:0]   eject_flit
);
    localparam int NumSrc = 5;
    localparam int AgeLsb = DATA_W + 2*XY_W;
    localparam logic [XY_W-1:0]  CurX   = XY_W'(CUR_X);
    localparam logic [XY_W-1:0]  CurY   = XY_W'(CUR_Y);
    localparam logic [AGE_W-1:0] AgeMax = '1;

    function automatic logic [XY_W-1:0] dstX(input logic [FLIT_W-1:0] f);
        return f[DATA_W +: XY_W];
    endfunction

    function automatic logic [XY_W-1:0] dstY(input logic [FLIT_W-1:0] f);
        return f[DATA_W+XY_W +: XY_W];
    endfunction

    function automatic logic [AGE_W-1:0] ageOf(input logic [FLIT_W-1:0] f);
        return f[AgeLsb +: AGE_W];
    endfunction

    function automatic logic isLocal(input logic [FLIT_W-1:0] f);
        return (dstX(f) == CurX) && (dstY(f) == CurY);
    endfunction

    // A flit that is local but not ejected may leave on any free port.
    function automatic logic [3:0] routePpv(input logic [FLIT_W-1:0] f);
        logic [3:0] p;
        p    = 4'b0000;
        p[0] = dstY(f) > CurY;
        p[1] = dstX(f) > CurX;
        p[2] = dstY(f) < CurY;
        p[3] = dstX(f) < CurX;
        if (isLocal(f)) p = 4'b1111;
        return p;
    endfunction

    logic [FLIT_W-1:0] netFlit [4];
    logic [3:0]        ejectCand;
    logic              ejectHit;
    logic [1:0]        ejectIdx;
    logic [AGE_W-1:0]  ejectAge;

    logic [NumSrc-1:0] srcValid;
    logic [FLIT_W-1:0] srcFlit [NumSrc];
    logic [AGE_W-1:0]  srcKey  [NumSrc];
    logic [3:0]        srcPpv  [NumSrc];
    logic [2:0]        netCnt;
    logic [AGE_W-1:0]  curAge;

    logic [2:0]          srcPos [NumSrc];
    logic [3:0]          nxtValid;
    logic [4*FLIT_W-1:0] nxtFlit;
    logic [15:0]         nxtPpv;
    logic [3:0]          nxtMc;
    logic [2:0]          nxtCnt;
    logic [FLIT_W-1:0]   nxtEjectFlit;

    // Ejection pick: oldest local flit, strict compare keeps the lowest port on ties.
    always_comb begin
        ejectHit = 1'b0;
        ejectIdx = 2'd0;
        ejectAge = '0;
        for (int i = 0; i < 4; i++) begin
            netFlit[i]   = in_flit[i*FLIT_W +: FLIT_W];
            ejectCand[i] = in_valid[i] && isLocal(netFlit[i]);
        end
        for (int i = 0; i < 4; i++) begin
            if (ejectCand[i] && (!ejectHit || ageOf(netFlit[i]) > ejectAge)) begin
                ejectHit = 1'b1;
                ejectIdx = 2'(i);
                ejectAge = ageOf(netFlit[i]);
            end
        end
        nxtEjectFlit = ejectHit ? netFlit[ejectIdx] : '0;
    end

    // Sources 0..3 are the network ports, source 4 is the injection slot.
    always_comb begin
        netCnt = 3'd0;
        curAge = '0;
        for (int i = 0; i < 4; i++) begin
            srcValid[i] = in_valid[i] && !(ejectHit && ejectIdx == 2'(i));
            curAge      = ageOf(netFlit[i]);
            srcKey[i]   = curAge;
            srcFlit[i]  = netFlit[i];
            srcFlit[i][AgeLsb +: AGE_W] = (curAge == AgeMax) ? AgeMax : curAge + 1'b1;
            srcPpv[i]   = routePpv(netFlit[i]);
            netCnt      = netCnt + {2'b00, srcValid[i]};
        end
        inj_ready   = (netCnt != 3'd4);
        srcValid[4] = inj_valid && inj_ready;
        srcKey[4]   = '0;
        srcFlit[4]  = inj_flit;
        srcFlit[4][AgeLsb +: AGE_W] = '0;
        srcPpv[4]   = routePpv(inj_flit);
    end

    // Rank of a source = number of valid sources that are older, or equally old with a lower index.
    always_comb begin
        nxtValid = '0;
        nxtFlit  = '0;
        nxtPpv   = '0;
        nxtMc    = '0;
        nxtCnt   = 3'd0;
        for (int s = 0; s < NumSrc; s++) begin
            srcPos[s] = 3'd0;
            for (int t = 0; t < NumSrc; t++) begin
                if (srcValid[t] && (srcKey[t] > srcKey[s] || (srcKey[t] == srcKey[s] && t < s)))
                    srcPos[s] = srcPos[s] + 3'd1;
            end
            nxtCnt = nxtCnt + {2'b00, srcValid[s]};
        end
        for (int r = 0; r < 4; r++) begin
            for (int s = 0; s < NumSrc; s++) begin
                if (srcValid[s] && srcPos[s] == 3'(r)) begin
                    nxtValid[r]                 = 1'b1;
                    nxtFlit[r*FLIT_W +: FLIT_W] = srcFlit[s];
                    nxtPpv[r*4 +: 4]            = srcPpv[s];
                    nxtMc[r]                    = srcFlit[s][FLIT_W-1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rank_valid  <= '0;
            rank_flit   <= '0;
            rank_ppv    <= '0;
            rank_mc     <= '0;
            rank_cnt    <= '0;
            eject_valid <= 1'b0;
            eject_flit  <= '0;
        end else begin
            rank_valid  <= nxtValid;
            rank_flit   <= nxtFlit;
            rank_ppv    <= nxtPpv;
            rank_mc     <= nxtMc;
            rank_cnt    <= nxtCnt;
            eject_valid <= ejectHit;
            eject_flit  <= nxtEjectFlit;
        end
    end
endmodule
